// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and byte/word helpers.
// Purely combinational content; no latency or flow control of its own.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_KEY_EXP = 2'd1,
        ST_RUN     = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam int AES_NR = 10;

    // Tables are stored with entry 0 in the most significant byte.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8'hff - b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[8'hff - b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES round (forward or inverse); zero latency, no flow control.
// The last flag drops (Inv)MixColumns for the final round.
module aes_round_unit
    import aes_pkg::*;
#(
    parameter bit ENABLE_DECRYPT = 1'b1
) (
    input  logic [127:0] i_state,
    input  logic [127:0] i_rkey,
    input  logic         i_decrypt,
    input  logic         i_last,
    output logic [127:0] o_state
);

    // Byte n of the state sits at bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [7:0] get_b(input logic [127:0] s, input int n);
        return s[127-8*n -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++)
            o[127-8*n -: 8] = inv ? inv_sbox(get_b(s, n)) : sbox(get_b(s, n));
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv ? get_b(s, 4*((c+4-r)%4)+r)
                                            : get_b(s, 4*((c+r)%4)+r);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        logic [7:0]   k0, k1, k2, k3;
        o  = '0;
        k0 = inv ? 8'h0e : 8'h02;
        k1 = inv ? 8'h0b : 8'h03;
        k2 = inv ? 8'h0d : 8'h01;
        k3 = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            a0 = get_b(s, 4*c);
            a1 = get_b(s, 4*c+1);
            a2 = get_b(s, 4*c+2);
            a3 = get_b(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0,k0) ^ gmul(a1,k1) ^ gmul(a2,k2) ^ gmul(a3,k3);
            o[127-8*(4*c+1) -: 8] = gmul(a0,k3) ^ gmul(a1,k0) ^ gmul(a2,k1) ^ gmul(a3,k2);
            o[127-8*(4*c+2) -: 8] = gmul(a0,k2) ^ gmul(a1,k3) ^ gmul(a2,k0) ^ gmul(a3,k1);
            o[127-8*(4*c+3) -: 8] = gmul(a0,k1) ^ gmul(a1,k2) ^ gmul(a2,k3) ^ gmul(a3,k0);
        end
        return o;
    endfunction

    logic [127:0] w_enc_sr;
    logic [127:0] w_enc;

    assign w_enc_sr = shift_rows(sub_bytes(i_state, 1'b0), 1'b0);
    assign w_enc    = (i_last ? w_enc_sr : mix_columns(w_enc_sr, 1'b0)) ^ i_rkey;

    if (ENABLE_DECRYPT) begin : g_dec
        logic [127:0] w_dec_ark;
        assign w_dec_ark = sub_bytes(shift_rows(i_state, 1'b1), 1'b1) ^ i_rkey;
        assign o_state   = !i_decrypt ? w_enc
                         : (i_last ? w_dec_ark : mix_columns(w_dec_ark, 1'b1));
    end else begin : g_enc_only
        logic w_unused_dec;
        assign w_unused_dec = i_decrypt;
        assign o_state      = w_enc;
    end

endmodule

// File: rtl/aes_block_engine.sv
// Iterative AES-128 engine with a resident key schedule; result 10/ROUNDS_PER_CYCLE cycles after accept.
// Result is held until out_ready; a new block is taken in the same cycle the held result drains.
module aes_block_engine
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit ENABLE_DECRYPT   = 1'b1,
    parameter int TAG_W            = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [127:0]     key,
    output logic             key_loaded,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic             in_decrypt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int ITERS = AES_NR / ROUNDS_PER_CYCLE;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [127:0]       r_rk [11];
    logic [3:0]         r_kcnt;
    logic [127:0]       r_st;
    logic [TAG_W-1:0]   r_tag;
    logic               r_dec;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_key_loaded;
    logic               r_out_valid;
    logic [127:0]       r_out_data;
    logic [TAG_W-1:0]   r_out_tag;

    logic               w_key_hs;
    logic               w_in_hs;
    logic               w_out_hs;
    logic               w_in_dec;
    logic               w_run_last;
    logic [127:0]       w_chain [ROUNDS_PER_CYCLE+1];

    function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word(rot_word(rk[31:0])) ^ {rc, 24'h000000};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64]  ^ n0;
        n2 = rk[63:32]  ^ n1;
        n3 = rk[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign key_ready  = (r_state == ST_IDLE);
    assign in_ready   = r_key_loaded && !key_valid
                     && (r_state == ST_IDLE || (r_state == ST_HOLD && out_ready));
    assign w_key_hs   = key_valid && key_ready;
    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_in_dec   = ENABLE_DECRYPT & in_decrypt;
    assign w_run_last = (r_cnt == CNT_LAST);

    assign key_loaded = r_key_loaded;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_tag    = r_out_tag;
    assign busy       = (r_state != ST_IDLE);

    // Round unit k of this cycle handles absolute round r_cnt*ROUNDS_PER_CYCLE+k+1.
    assign w_chain[0] = r_st;
    for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
        logic [3:0]   w_ridx;
        logic [127:0] w_rkey;
        assign w_ridx = 4'(int'(r_cnt) * ROUNDS_PER_CYCLE + k + 1);
        assign w_rkey = r_dec ? r_rk[4'd10 - w_ridx] : r_rk[w_ridx];
        aes_round_unit #(.ENABLE_DECRYPT(ENABLE_DECRYPT)) u_round (
            .i_state   (w_chain[k]),
            .i_rkey    (w_rkey),
            .i_decrypt (r_dec),
            .i_last    (w_ridx == 4'd10),
            .o_state   (w_chain[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_key_hs)     w_next_state = ST_KEY_EXP;
                else if (w_in_hs) w_next_state = ST_RUN;
            end
            ST_KEY_EXP: if (r_kcnt == 4'd10) w_next_state = ST_IDLE;
            ST_RUN:     if (w_run_last)      w_next_state = ST_HOLD;
            ST_HOLD: begin
                if (w_in_hs)       w_next_state = ST_RUN;
                else if (w_out_hs) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Schedule is only rewritten after a key handshake, which cannot happen mid-block.
    always_ff @(posedge clk) begin
        if (w_key_hs)
            r_rk[0] <= key;
        else if (r_state == ST_KEY_EXP)
            r_rk[r_kcnt] <= key_step(r_rk[r_kcnt - 4'd1], RCON[r_kcnt]);
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_st  <= in_data ^ (w_in_dec ? r_rk[10] : r_rk[0]);
            r_tag <= in_tag;
            r_dec <= w_in_dec;
        end else if (r_state == ST_RUN) begin
            r_st  <= w_chain[ROUNDS_PER_CYCLE];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_loaded <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_tag    <= '0;
            r_cnt        <= '0;
            r_kcnt       <= 4'd0;
        end else begin
            if (w_key_hs) begin
                r_key_loaded <= 1'b0;
                r_kcnt       <= 4'd1;
            end else if (r_state == ST_KEY_EXP) begin
                r_kcnt <= r_kcnt + 4'd1;
                if (r_kcnt == 4'd10) r_key_loaded <= 1'b1;
            end

            if (w_out_hs) r_out_valid <= 1'b0;

            if (w_in_hs) begin
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_run_last) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_chain[ROUNDS_PER_CYCLE];
                    r_out_tag   <= r_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_block_engine.sv
// Directed FIPS-197 vectors plus flow-control, key-priority and reset scenarios.
module tb_aes_block_engine;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         rst_n;
    logic         key_valid, key_ready, key_loaded;
    logic [127:0] key;
    logic         in_valid, in_ready, in_decrypt;
    logic [127:0] in_data;
    logic [3:0]   in_tag;
    logic         out_valid, out_ready, busy;
    logic [127:0] out_data;
    logic [3:0]   out_tag;

    // Shared stimulus for the unrolled instances (R=2 encrypt-only, R=5 full).
    logic         m_key_valid, m_in_valid, m_out_ready, m_dec2, m_dec5;
    logic [127:0] m_key, m_in_data;
    logic [3:0]   m_in_tag;
    logic         k2_ready, k2_loaded, i2_ready, o2_valid, b2;
    logic         k5_ready, k5_loaded, i5_ready, o5_valid, b5;
    logic [127:0] o2_data, o5_data;
    logic [3:0]   o2_tag, o5_tag;

    aes_block_engine #(.ROUNDS_PER_CYCLE(1), .ENABLE_DECRYPT(1'b1), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready), .key(key), .key_loaded(key_loaded),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_decrypt(in_decrypt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy)
    );

    aes_block_engine #(.ROUNDS_PER_CYCLE(2), .ENABLE_DECRYPT(1'b0), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .key_valid(m_key_valid), .key_ready(k2_ready), .key(m_key), .key_loaded(k2_loaded),
        .in_valid(m_in_valid), .in_ready(i2_ready), .in_data(m_in_data),
        .in_decrypt(m_dec2), .in_tag(m_in_tag),
        .out_valid(o2_valid), .out_ready(m_out_ready), .out_data(o2_data),
        .out_tag(o2_tag), .busy(b2)
    );

    aes_block_engine #(.ROUNDS_PER_CYCLE(5), .ENABLE_DECRYPT(1'b1), .TAG_W(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n),
        .key_valid(m_key_valid), .key_ready(k5_ready), .key(m_key), .key_loaded(k5_loaded),
        .in_valid(m_in_valid), .in_ready(i5_ready), .in_data(m_in_data),
        .in_decrypt(m_dec5), .in_tag(m_in_tag),
        .out_valid(o5_valid), .out_ready(m_out_ready), .out_data(o5_data),
        .out_tag(o5_tag), .busy(b5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles from the handshake cycle (counted as 1) to key_loaded=1.
    task automatic load_key(input logic [127:0] k, output int cyc);
        key       = k;
        key_valid = 1'b1;
        #1;
        tick();
        key_valid = 1'b0;
        cyc = 1;
        while (!key_loaded && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Returns cycles from the input handshake edge to out_valid rising.
    task automatic send_block(input logic [127:0] d, input logic dec, input logic [3:0] tg,
                              output int lat);
        int w;
        in_data    = d;
        in_decrypt = dec;
        in_tag     = tg;
        in_valid   = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (key_loaded !== 1'b0) begin errors++; $display("FAIL rst_key_loaded: got %b want 0", key_loaded); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rst_key_ready: got %b want 1", key_ready); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL rst_out_tag: got %h want 0", out_tag); end
        rst_n    = 1'b1;
        in_data  = C1_PT;
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nokey_in_ready: got %b want 0", in_ready); end
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nokey_busy: got %b want 0", busy); end
        in_valid = 1'b0;
    endtask

    task automatic test_c1_encrypt();
        int cyc, lat;
        load_key(C1_KEY, cyc);
        checks++; if (cyc !== 11) begin errors++; $display("FAIL c1_key_cycles: got %0d want 11", cyc); end
        send_block(C1_PT, 1'b0, 4'h5, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL c1_latency: got %0d want 10", lat); end
        checks++; if (out_data !== C1_CT) begin errors++; $display("FAIL c1_ct: got %h want %h", out_data, C1_CT); end
        checks++; if (out_tag !== 4'h5) begin errors++; $display("FAIL c1_tag: got %h want 5", out_tag); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL c1_hold_busy: got %b want 1", busy); end
        drain();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL c1_drain_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c1_drain_busy: got %b want 0", busy); end
    endtask

    task automatic test_c1_decrypt();
        int lat;
        send_block(C1_CT, 1'b1, 4'ha, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL c1d_latency: got %0d want 10", lat); end
        checks++; if (out_data !== C1_PT) begin errors++; $display("FAIL c1d_pt: got %h want %h", out_data, C1_PT); end
        checks++; if (out_tag !== 4'ha) begin errors++; $display("FAIL c1d_tag: got %h want a", out_tag); end
        checks++; if (key_loaded !== 1'b1) begin errors++; $display("FAIL c1d_key_loaded: got %b want 1", key_loaded); end
        drain();
    endtask

    task automatic test_appb_r1();
        int cyc, lat;
        load_key(B_KEY, cyc);
        checks++; if (cyc !== 11) begin errors++; $display("FAIL b_key_cycles: got %0d want 11", cyc); end
        send_block(B_PT, 1'b0, 4'h2, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL b_latency: got %0d want 10", lat); end
        checks++; if (out_data !== B_CT) begin errors++; $display("FAIL b_ct: got %h want %h", out_data, B_CT); end
        drain();
    endtask

    task automatic test_unroll();
        int w, lat2, lat5;
        logic [127:0] d2, d5;
        m_key       = B_KEY;
        m_key_valid = 1'b1;
        #1;
        tick();
        m_key_valid = 1'b0;
        w = 0;
        while (!(k2_loaded && k5_loaded) && w < 40) begin
            tick();
            w++;
        end
        checks++; if (k2_loaded !== 1'b1) begin errors++; $display("FAIL r2_key_loaded: got %b want 1", k2_loaded); end
        checks++; if (k5_loaded !== 1'b1) begin errors++; $display("FAIL r5_key_loaded: got %b want 1", k5_loaded); end
        m_in_data  = B_PT;
        m_in_tag   = 4'h7;
        m_dec5     = 1'b0;
        m_in_valid = 1'b1;
        #1;
        checks++; if ({i2_ready, i5_ready} !== 2'b11) begin errors++; $display("FAIL unroll_in_ready: got %b want 11", {i2_ready, i5_ready}); end
        tick();
        m_in_valid = 1'b0;
        lat2 = -1; lat5 = -1; d2 = '0; d5 = '0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (lat2 < 0 && o2_valid) begin lat2 = n; d2 = o2_data; end
            if (lat5 < 0 && o5_valid) begin lat5 = n; d5 = o5_data; end
        end
        checks++; if (lat2 !== 5) begin errors++; $display("FAIL r2_latency: got %0d want 5", lat2); end
        checks++; if (d2 !== B_CT) begin errors++; $display("FAIL r2_ct_encrypt_only: got %h want %h", d2, B_CT); end
        checks++; if (lat5 !== 2) begin errors++; $display("FAIL r5_latency: got %0d want 2", lat5); end
        checks++; if (d5 !== B_CT) begin errors++; $display("FAIL r5_ct: got %h want %h", d5, B_CT); end
        checks++; if (o5_tag !== 4'h7) begin errors++; $display("FAIL r5_tag: got %h want 7", o5_tag); end
        m_out_ready = 1'b1;
        tick();
        m_out_ready = 1'b0;
        m_in_data  = B_CT;
        m_dec5     = 1'b1;
        m_in_valid = 1'b1;
        #1;
        tick();
        m_in_valid = 1'b0;
        lat5 = -1; d5 = '0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (lat5 < 0 && o5_valid) begin lat5 = n; d5 = o5_data; end
        end
        checks++; if (d5 !== B_PT) begin errors++; $display("FAIL r5_decrypt: got %h want %h", d5, B_PT); end
        m_out_ready = 1'b1;
        tick();
        m_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat, bad_stable, bad_ready;
        send_block(B_PT, 1'b0, 4'h9, lat);
        in_data    = B_CT;
        in_decrypt = 1'b1;
        in_tag     = 4'h3;
        in_valid   = 1'b1;
        bad_stable = 0;
        bad_ready  = 0;
        for (int n = 0; n < 20; n++) begin
            if (!out_valid || out_data !== B_CT || out_tag !== 4'h9) bad_stable++;
            if (in_ready !== 1'b0) bad_ready++;
            tick();
        end
        checks++; if (bad_stable !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d bad cycles want 0", bad_stable); end
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL bp_in_ready_low: got %0d bad cycles want 0", bad_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b11) begin errors++; $display("FAIL bp_dual_handshake: got %b want 11", {out_valid, in_ready}); end
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if ({out_valid, busy} !== 2'b01) begin errors++; $display("FAIL bp_after_hs: got %b want 01", {out_valid, busy}); end
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 10) begin errors++; $display("FAIL bp_next_latency: got %0d want 10", lat); end
        checks++; if (out_data !== B_PT) begin errors++; $display("FAIL bp_next_data: got %h want %h", out_data, B_PT); end
        checks++; if (out_tag !== 4'h3) begin errors++; $display("FAIL bp_next_tag: got %h want 3", out_tag); end
        drain();
    endtask

    task automatic test_key_priority();
        int lat, cyc;
        send_block(B_PT, 1'b0, 4'h1, lat);
        key       = C1_KEY;
        key_valid = 1'b1;
        #1;
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL hold_key_ready: got %b want 0", key_ready); end
        repeat (3) tick();
        checks++; if ({key_loaded, busy} !== 2'b11) begin errors++; $display("FAIL hold_key_ignored: got %b want 11", {key_loaded, busy}); end
        key_valid = 1'b0;
        drain();
        key        = C1_KEY;
        key_valid  = 1'b1;
        in_data    = C1_PT;
        in_decrypt = 1'b0;
        in_tag     = 4'h6;
        in_valid   = 1'b1;
        #1;
        checks++; if ({key_ready, in_ready} !== 2'b10) begin errors++; $display("FAIL prio_ready: got %b want 10", {key_ready, in_ready}); end
        tick();
        key_valid = 1'b0;
        cyc = 1;
        while (!key_loaded && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++; if (cyc !== 11) begin errors++; $display("FAIL prio_key_cycles: got %0d want 11", cyc); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_block_waiting: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (out_data !== C1_CT) begin errors++; $display("FAIL prio_ct: got %h want %h", out_data, C1_CT); end
        checks++; if (out_tag !== 4'h6) begin errors++; $display("FAIL prio_tag: got %h want 6", out_tag); end
        drain();
    endtask

    task automatic test_reset_mid_run();
        in_data    = C1_PT;
        in_decrypt = 1'b0;
        in_tag     = 4'h4;
        in_valid   = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_run_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        checks++; if (key_loaded !== 1'b0) begin errors++; $display("FAIL mid_rst_key_loaded: got %b want 0", key_loaded); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_key_ready: got %b want 1", key_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL mid_rst_out_data: got %h want 0", out_data); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        key_valid = 1'b0; key = '0; in_valid = 1'b0; in_data = '0;
        in_decrypt = 1'b0; in_tag = '0; out_ready = 1'b0;
        m_key_valid = 1'b0; m_key = '0; m_in_valid = 1'b0; m_in_data = '0;
        m_in_tag = '0; m_out_ready = 1'b0; m_dec2 = 1'b1; m_dec5 = 1'b0;
        test_reset();
        test_c1_encrypt();
        test_c1_decrypt();
        test_appb_r1();
        test_unroll();
        test_backpressure();
        test_key_priority();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
